// File: rtl/sm4_key_sched.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys at UNROLL rounds/cycle,
// stores them, and streams them in encrypt or decrypt order with replay and a random-access read port.
module sm4_key_sched #(
  parameter int UNROLL = 1
) (
  input  logic         clk_sys,
  input  logic         sys_rst_n,
  input  logic [127:0] key_in,
  input  logic         key_in_vld,
  output logic         key_in_rdy,
  input  logic         key_dec,
  input  logic         replay_vld,
  input  logic         replay_dec,
  output logic [31:0]  rkey_out,
  output logic [4:0]   rkey_idx,
  output logic         rkey_last,
  output logic         rkey_vld,
  input  logic         rkey_rdy,
  input  logic [4:0]   rd_idx,
  output logic [31:0]  rd_key,
  output logic         keys_ready,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sm4_key_sched: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [4:0]   CNT_STEP = 5'(UNROLL);
  localparam logic [4:0]   LAST_CNT = 5'(32 - UNROLL);
  localparam logic [127:0] FK       = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] k_q [4];
  logic [31:0] k_d [4];
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        dec_q, dec_d;
  logic        keys_ready_q, keys_ready_d;
  logic [31:0] rd_key_q, rd_key_d;
  logic [31:0] store_q [32];
  logic [31:0] store_d [32];
  logic [31:0] rnd_key [UNROLL];
  logic [31:0] rnd_win [4];

  // CK_i byte j is (4i+j)*7 mod 256, so the word is four bytes spaced by 7 from 28*i.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [7:0] base;
    base = 8'({i, 2'b00}) * 8'd7;
    return {base, base + 8'd7, base + 8'd14, base + 8'd21};
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] a);
    logic [31:0] b;
    b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Slide the four-word window through UNROLL chained rounds starting at round cnt_q.
  always_comb begin : round_chain
    logic [31:0] w0, w1, w2, w3, nk;
    w0 = k_q[0];
    w1 = k_q[1];
    w2 = k_q[2];
    w3 = k_q[3];
    for (int u = 0; u < UNROLL; u++) begin
      nk = w0 ^ t_prime(w1 ^ w2 ^ w3 ^ ck_word(cnt_q + 5'(u)));
      rnd_key[u] = nk;
      w0 = w1;
      w1 = w2;
      w2 = w3;
      w3 = nk;
    end
    rnd_win = '{w0, w1, w2, w3};
  end

  always_comb begin
    store_d = store_q;
    if (state_q == EXPAND) begin
      for (int u = 0; u < UNROLL; u++) store_d[cnt_q + 5'(u)] = rnd_key[u];
    end
  end

  assign key_in_rdy = (state_q == IDLE) || (state_q == DONE);
  assign rkey_vld   = (state_q == STREAM);
  assign rkey_last  = rkey_vld && (ptr_q == (dec_q ? 5'd0 : 5'd31));
  assign rkey_out   = rkey_vld ? store_q[ptr_q] : '0;
  assign rkey_idx   = rkey_vld ? ptr_q : '0;
  assign busy       = (state_q == EXPAND) || (state_q == STREAM);
  assign keys_ready = keys_ready_q;
  assign rd_key     = rd_key_q;
  assign rd_key_d   = store_q[rd_idx];

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    dec_d        = dec_q;
    keys_ready_d = keys_ready_q;
    case (state_q)
      IDLE, DONE: begin
        // A new key always takes priority over a replay offered in the same cycle.
        if (key_in_vld) begin
          state_d      = EXPAND;
          k_d          = '{key_in[127:96] ^ FK[127:96], key_in[95:64] ^ FK[95:64],
                           key_in[63:32] ^ FK[63:32], key_in[31:0] ^ FK[31:0]};
          cnt_d        = '0;
          dec_d        = key_dec;
          keys_ready_d = 1'b0;
        end else if (state_q == DONE && replay_vld) begin
          state_d = STREAM;
          dec_d   = replay_dec;
          ptr_d   = replay_dec ? 5'd31 : 5'd0;
        end
      end
      EXPAND: begin
        k_d   = rnd_win;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) begin
          state_d      = STREAM;
          keys_ready_d = 1'b1;
          ptr_d        = dec_q ? 5'd31 : 5'd0;
        end
      end
      STREAM: begin
        if (rkey_rdy) begin
          if (rkey_last) state_d = DONE;
          else           ptr_d   = dec_q ? ptr_q - 5'd1 : ptr_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      k_q          <= '{default: '0};
      cnt_q        <= '0;
      ptr_q        <= '0;
      dec_q        <= 1'b0;
      keys_ready_q <= 1'b0;
      rd_key_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      dec_q        <= dec_d;
      keys_ready_q <= keys_ready_d;
      rd_key_q     <= rd_key_d;
    end
  end

  // The key store needs no reset: its contents are masked by keys_ready.
  always_ff @(posedge clk_sys) begin
    store_q <= store_d;
  end

endmodule

// File: tb/tb_sm4_key_sched.sv
// Scoreboard bench for sm4_key_sched: four instances (UNROLL 1/2/4/8) share stimulus and are
// checked against a behavioural SM4 key-expansion model.
module tb_sm4_key_sched;
  localparam int NI = 4;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] key;
    logic        last;
    logic [31:0] due;
  } beat_t;

  localparam logic [31:0] FK_W [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  localparam logic [127:0] MK_REF = 128'h01234567_89abcdef_fedcba98_76543210;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk_sys = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_in_vld = 1'b0;
  logic         key_dec = 1'b0;
  logic         replay_vld = 1'b0;
  logic         replay_dec = 1'b0;
  logic         rkey_rdy = 1'b1;
  logic [4:0]   rd_idx = '0;

  logic         key_in_rdy [NI];
  logic [31:0]  rkey_out [NI];
  logic [4:0]   rkey_idx [NI];
  logic         rkey_last [NI];
  logic         rkey_vld [NI];
  logic [31:0]  rd_key [NI];
  logic         keys_ready [NI];
  logic         busy [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] model_rk [32];
  beat_t sb_q [NI][$];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: straight from the key-expansion recurrence over a 36-word array.
  function automatic logic [31:0] tau_l(input logic [31:0] a);
    logic [31:0] b;
    b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
  endfunction

  task automatic compute_schedule(input logic [127:0] mk);
    logic [31:0] kk [36];
    logic [31:0] ck;
    for (int j = 0; j < 4; j++) kk[j] = mk[127 - 32*j -: 32] ^ FK_W[j];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
      kk[i+4] = kk[i] ^ tau_l(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
      model_rk[i] = kk[i+4];
    end
  endtask

  task automatic push_stream(input logic dec, input int acc, input bit lat);
    beat_t b;
    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < 32; n++) begin
        b.idx  = 5'(dec ? 31 - n : n);
        b.key  = model_rk[dec ? 31 - n : n];
        b.last = (n == 31);
        b.due  = (lat && n == 0) ? 32'(acc + (32 >> g) + 1) : 32'd0;
        sb_q[g].push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input logic [127:0] mk, input logic dec, input bit with_replay, input bit lat);
    int acc;
    @(posedge clk_sys); #1;
    for (int g = 0; g < NI; g++) checkOutput($sformatf("key_in_rdy_u%0d", 1 << g), key_in_rdy[g], 1);
    key_in = mk;
    key_dec = dec;
    key_in_vld = 1'b1;
    replay_vld = with_replay;
    replay_dec = ~dec;
    acc = cyc + 1;
    compute_schedule(mk);
    push_stream(dec, acc, lat);
    @(posedge clk_sys); #1;
    key_in_vld = 1'b0;
    replay_vld = 1'b0;
    for (int g = 0; g < NI; g++)
      checkOutput($sformatf("accept_kr_busy_u%0d", 1 << g), {keys_ready[g], busy[g]}, 2'b01);
  endtask

  task automatic replayStream(input logic dec);
    @(posedge clk_sys); #1;
    replay_vld = 1'b1;
    replay_dec = dec;
    push_stream(dec, 0, 1'b0);
    @(posedge clk_sys); #1;
    replay_vld = 1'b0;
    for (int g = 0; g < NI; g++)
      checkOutput($sformatf("replay_kr_busy_u%0d", 1 << g), {keys_ready[g], busy[g]}, 2'b11);
  endtask

  task automatic waitAllDone(input bit rand_rdy, input string name);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 3000) begin
      @(posedge clk_sys); #1;
      t++;
      if (rand_rdy) rkey_rdy = 1'($urandom_range(0, 1));
      done = 1'b1;
      for (int g = 0; g < NI; g++) if (busy[g] || sb_q[g].size() != 0) done = 1'b0;
    end
    rkey_rdy = 1'b1;
    checkOutput({name, "_complete"}, done, 1);
  endtask

  task automatic checkRead(input logic [4:0] idx, input logic [31:0] exp, input string name);
    rd_idx = idx;
    @(posedge clk_sys); #1;
    for (int g = 0; g < NI; g++)
      checkOutput($sformatf("%s_u%0d_idx%0d", name, 1 << g, idx), {keys_ready[g], rd_key[g]}, {1'b1, exp});
  endtask

  task automatic checkResetOutputs(input string name);
    for (int g = 0; g < NI; g++)
      checkOutput($sformatf("%s_u%0d", name, 1 << g),
                  {key_in_rdy[g], rkey_vld[g], rkey_last[g], rkey_idx[g], rkey_out[g], rd_key[g], keys_ready[g], busy[g]},
                  {1'b1, 73'd0});
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sm4_key_sched #(.UNROLL(1 << g)) dut (
      .clk_sys    (clk_sys),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in),
      .key_in_vld (key_in_vld),
      .key_in_rdy (key_in_rdy[g]),
      .key_dec    (key_dec),
      .replay_vld (replay_vld),
      .replay_dec (replay_dec),
      .rkey_out   (rkey_out[g]),
      .rkey_idx   (rkey_idx[g]),
      .rkey_last  (rkey_last[g]),
      .rkey_vld   (rkey_vld[g]),
      .rkey_rdy   (rkey_rdy),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key[g]),
      .keys_ready (keys_ready[g]),
      .busy       (busy[g])
    );

    beat_t held;
    bit    held_v = 1'b0;

    // Monitor: pop the scoreboard on every transfer, and hold a stalled beat for comparison.
    always @(negedge clk_sys) begin
      beat_t exp_b;
      if (!sys_rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v)
          checkOutput($sformatf("stall_hold_u%0d", 1 << g),
                      {rkey_vld[g], rkey_idx[g], rkey_out[g], rkey_last[g]},
                      {1'b1, held.idx, held.key, held.last});
        held_v = 1'b0;
        if (rkey_vld[g]) begin
          if (rkey_rdy) begin
            if (sb_q[g].size() == 0) begin
              checkOutput($sformatf("unexpected_beat_u%0d", 1 << g), rkey_vld[g], 0);
            end else begin
              exp_b = sb_q[g].pop_front();
              checkOutput($sformatf("beat_u%0d_idx%0d", 1 << g, exp_b.idx),
                          {rkey_idx[g], rkey_out[g], rkey_last[g]}, {exp_b.idx, exp_b.key, exp_b.last});
              if (exp_b.due != 0)
                checkOutput($sformatf("first_beat_latency_u%0d", 1 << g), 32'(cyc + 1), exp_b.due);
            end
          end else begin
            held.idx  = rkey_idx[g];
            held.key  = rkey_out[g];
            held.last = rkey_last[g];
            held.due  = '0;
            held_v    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] rk;
    logic         rd;
    int           t;

    #2;
    checkResetOutputs("reset_state");
    #20;
    sys_rst_n = 1'b1;

    $display("[TB] reference key, encrypt order");
    applyStimulus(MK_REF, 1'b0, 1'b0, 1'b1);
    waitAllDone(1'b0, "ref_enc");

    $display("[TB] reference key, decrypt order");
    applyStimulus(MK_REF, 1'b1, 1'b0, 1'b1);
    waitAllDone(1'b0, "ref_dec");
    checkRead(5'd0, 32'hf12186f9, "rd_ref");
    checkRead(5'd31, 32'h9124a012, "rd_ref");

    $display("[TB] random key with backpressure and ignored offers");
    rk = {$urandom, $urandom, $urandom, $urandom};
    rd = 1'($urandom_range(0, 1));
    applyStimulus(rk, rd, 1'b0, 1'b0);
    key_in = ~rk;
    key_in_vld = 1'b1;
    replay_vld = 1'b1;
    for (int g = 0; g < NI; g++)
      checkOutput($sformatf("busy_rdy_low_u%0d", 1 << g), {key_in_rdy[g], busy[g]}, 2'b01);
    @(posedge clk_sys); #1;
    key_in_vld = 1'b0;
    replay_vld = 1'b0;
    waitAllDone(1'b1, "rand_stall");
    for (int k = 0; k < 4; k++) begin
      t = $urandom_range(0, 31);
      checkRead(5'(t), model_rk[t], "rd_rand");
    end

    $display("[TB] replay without re-expansion");
    replayStream(~rd);
    waitAllDone(1'b1, "replay");

    $display("[TB] key and replay together");
    rk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rk, 1'b0, 1'b1, 1'b1);
    waitAllDone(1'b0, "key_wins");

    $display("[TB] reset in the middle of a stream");
    rk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rk, 1'b0, 1'b0, 1'b1);
    t = 0;
    while (sb_q[0].size() > 22 && t < 200) begin
      @(posedge clk_sys); #1;
      t++;
    end
    checkOutput("reset_point_reached", sb_q[0].size() <= 22, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkResetOutputs("reset_immediate");
    for (int g = 0; g < NI; g++) sb_q[g].delete();
    repeat (3) @(posedge clk_sys);
    #3;
    sys_rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk_sys); #1;
      for (int g = 0; g < NI; g++)
        checkOutput($sformatf("post_reset_u%0d", 1 << g),
                    {key_in_rdy[g], rkey_vld[g], keys_ready[g], busy[g]}, 4'b1000);
    end

    $display("[TB] recovery key after reset");
    rk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rk, 1'b1, 1'b0, 1'b1);
    waitAllDone(1'b0, "recovery");
    t = $urandom_range(0, 31);
    checkRead(5'(t), model_rk[t], "rd_recovery");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
